// File: rtl/pipe_pkg.sv
// Shared types and constants for elastic pipeline-stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy of a skid stage: nothing held, one entry in main, or main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  // All-zero word used as the bubble for IF/ID instances.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count visible the cycle after the increment request.
// Backpressure: none; inc is sampled every cycle.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: add one unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer and flush-to-bubble.
// Latency: 1 cycle in->out, 1 word/cycle sustained.
// Backpressure: in_ready comes only from the state register (low in SKID); no comb path from out_ready.
// Optional: define PIPE_STAGE_STALL_CNT_EN to add the stall_cnt output and its saturating counter.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              in_fire;
  logic              out_fire;

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and datapath: main always holds the oldest entry, skid the younger one.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = ST_SKID;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only a drain can happen.
        if (out_fire) begin
          state_d = ST_FULL;
          main_d  = skid_q;
          skid_d  = BUBBLE_VAL;
        end
      end
      default: begin
        // Unused encoding recovers by behaving as an empty stage.
        if (in_fire) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end else begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
        end
        skid_d = BUBBLE_VAL;
      end
    endcase
    // Flush kills both held entries and any word offered this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end
  end

  // State and payload registers with synchronous reset to an empty, bubbled stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Counts cycles where a live output is held back by downstream; only reset clears it.
  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg with a queue model of the stage occupancy.
// Latency: checks every cycle at the falling edge.
// Backpressure: driven explicitly through out_ready.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL ('0),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Model: ordered list of words held by the stage (at most two).
  logic [DATA_W-1:0] mq[$];
  int unsigned       mcnt;
  // Words the DUT actually handed downstream.
  logic [DATA_W-1:0] em[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record DUT emission, advance model at the edge, compare at the falling edge.
  task automatic step();
    bit inf;
    bit outf;
    if (out_valid === 1'b1 && out_ready) em.push_back(out_data);
    @(posedge clk);
    inf  = in_valid && (mq.size() < 2);
    outf = (mq.size() > 0) && out_ready;
    if (reset) mcnt = 0;
    else if ((mq.size() > 0) && !out_ready && (mcnt < CNT_MAX)) mcnt++;
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
    end
    @(negedge clk);
    chk("in_ready", DATA_W'(in_ready), DATA_W'(mq.size() < 2));
    chk("out_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
    chk("out_data", out_data, (mq.size() > 0) ? mq[0] : '0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(mcnt));
`endif
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hAA; out_ready = 1'b1;
    mcnt = 0;

    // 1: reset held two cycles with a word offered; it must never appear.
    step(); step();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", DATA_W'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", DATA_W'(in_ready), 64'd1);
    step();
    chk("rst_no_emit", 64'(em.size()), 64'd0);

    // 2: back-to-back stream, one cycle latency, never stalls.
    em.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      step();
      chk("stream_lat", out_data, 64'(i));
      chk("stream_rdy", DATA_W'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step(); step();
    chk("stream_cnt", 64'(em.size()), 64'd8);
    for (int i = 0; i < 8 && i < em.size(); i++) chk("stream_word", em[i], 64'(i + 1));

    // 3: backpressure fills the skid, then drains in order.
    em.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11;
    step();
    in_data = 64'h22;
    step();
    chk("bp_in_ready", DATA_W'(in_ready), 64'd0);
    chk("bp_hold", out_data, 64'h11);
    in_valid = 1'b0;
    step();
    chk("bp_hold2", out_data, 64'h11);
    out_ready = 1'b1;
    step(); step(); step();
    chk("bp_cnt", 64'(em.size()), 64'd2);
    if (em.size() == 2) begin
      chk("bp_first", em[0], 64'h11);
      chk("bp_second", em[1], 64'h22);
    end

    // 4: flush while in SKID with a third word offered.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1A;
    step();
    in_data = 64'h2B;
    step();
    em.delete();
    flush = 1'b1; in_data = 64'h33;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", DATA_W'(out_valid), 64'd0);
    chk("fl_out_data", out_data, 64'd0);
    chk("fl_in_ready", DATA_W'(in_ready), 64'd1);
    out_ready = 1'b1;
    step(); step(); step();
    chk("fl_no_emit", 64'(em.size()), 64'd0);

    // 5: reset in SKID, then a fresh word streams through.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
    step();
    in_data = 64'h66;
    step();
    reset = 1'b1; in_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("mr_out_valid", DATA_W'(out_valid), 64'd0);
    chk("mr_in_ready", DATA_W'(in_ready), 64'd1);
    em.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h44;
    step();
    in_valid = 1'b0;
    chk("mr_lat", out_data, 64'h44);
    step(); step();
    chk("mr_cnt", 64'(em.size()), 64'd1);
    if (em.size() == 1) chk("mr_word", em[0], 64'h44);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // 6: stall counter counts held cycles, saturates, survives a flush.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sc_reset", DATA_W'(stall_cnt), 64'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("sc_five", DATA_W'(stall_cnt), 64'd5);
    for (int i = 0; i < 5; i++) step();
    chk("sc_sat", DATA_W'(stall_cnt), 64'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("sc_flush", DATA_W'(stall_cnt), 64'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
